// File: rtl/des_scan_seq.sv
// rtl/des_scan_seq.sv - run/scan sequencer for the scan-equipped DES core
// One request runs the core, then shifts the scan chain out into a capture vector.
module des_scan_seq #(
  parameter int RUN_CYCLES = 3,
  parameter int CHAIN_LEN  = 512,
  parameter int SEG_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [63:0]          pt_in,
  input  logic [63:0]          key_in,
  input  logic                 decrypt_in,
  output logic                 busy,
  output logic                 done,
  output logic                 cap_valid,
  output logic [CHAIN_LEN-1:0] capture,
  output logic [63:0]          des_plaintext,
  output logic [63:0]          des_key,
  output logic                 des_decrypt,
  output logic                 des_testmode,
  input  logic                 des_sout
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int ROUNDS = CHAIN_LEN / SEG_W;

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  // Round-segmented view; round 1 occupies the top segment.
  logic [ROUNDS-1:0][SEG_W-1:0]   capture_q, capture_d;
  logic                           cap_valid_q, cap_valid_d;
  logic [63:0]                    pt_q, pt_d;
  logic [63:0]                    key_q, key_d;
  logic                           dec_q, dec_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture_d   = capture_q;
    cap_valid_d = cap_valid_q;
    pt_d        = pt_q;
    key_d       = key_q;
    dec_d       = dec_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pt_d        = pt_in;
          key_d       = key_in;
          dec_d       = decrypt_in;
          cap_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        // First sampled bit migrates to the MSB after CHAIN_LEN shifts.
        capture_d = CHAIN_LEN'({capture_q, des_sout});
        if (cnt_q == SHIFT_LAST) begin
          cnt_d       = '0;
          cap_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      capture_q   <= '0;
      cap_valid_q <= 1'b0;
      pt_q        <= '0;
      key_q       <= '0;
      dec_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      capture_q   <= capture_d;
      cap_valid_q <= cap_valid_d;
      pt_q        <= pt_d;
      key_q       <= key_d;
      dec_q       <= dec_d;
    end
  end

  // Status and core controls decode straight from the state flop so reset clears them at once.
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign des_testmode  = (state_q == S_SHIFT);
  assign cap_valid     = cap_valid_q;
  assign capture       = capture_q;
  assign des_plaintext = pt_q;
  assign des_key       = key_q;
  assign des_decrypt   = dec_q;

endmodule

// File: tb/tb_des_scan_seq.sv
// tb/tb_des_scan_seq.sv - directed bench for des_scan_seq
module tb_des_scan_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [63:0]  pt_in;
  logic [63:0]  key_in;
  logic         decrypt_in;
  logic         busy;
  logic         done;
  logic         cap_valid;
  logic [511:0] capture;
  logic [63:0]  des_plaintext;
  logic [63:0]  des_key;
  logic         des_decrypt;
  logic         des_testmode;
  logic         des_sout;

  localparam logic [63:0] KEY = 64'h2120040305192422;

  des_scan_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pt_in        (pt_in),
    .key_in       (key_in),
    .decrypt_in   (decrypt_in),
    .busy         (busy),
    .done         (done),
    .cap_valid    (cap_valid),
    .capture      (capture),
    .des_plaintext(des_plaintext),
    .des_key      (des_key),
    .des_decrypt  (des_decrypt),
    .des_testmode (des_testmode),
    .des_sout     (des_sout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core SOUT model: presents src_vec MSB first, one bit per TestMode cycle.
  logic [511:0] src_vec;
  int           src_idx;
  always @(negedge clk) begin
    if (!des_testmode) begin
      src_idx  = 511;
      des_sout = 1'b0;
    end else begin
      des_sout = src_vec[src_idx];
      if (src_idx > 0) src_idx--;
    end
  end

  // Starts from any idle point; cycle n is the n-th cycle after the accept edge.
  task automatic run_once(input logic [63:0] pt, input logic [63:0] key, input logic dec,
                          output logic cv_pre, output logic cv_acc,
                          output int rise_at, output int hi_cnt, output int done_at,
                          output logic stable);
    @(posedge clk); #1;
    cv_pre     = cap_valid;
    pt_in      = pt;
    key_in     = key;
    decrypt_in = dec;
    start      = 1'b1;
    @(posedge clk); #1;
    cv_acc     = cap_valid;
    start      = 1'b0;
    pt_in      = '1;
    key_in     = '1;
    decrypt_in = ~dec;
    rise_at = 0; hi_cnt = 0; done_at = 0; stable = 1'b1;
    for (int n = 1; n <= 600 && done_at == 0; n++) begin
      @(negedge clk);
      if (des_testmode) begin
        hi_cnt++;
        if (rise_at == 0) rise_at = n;
      end
      if (des_key !== key || des_plaintext !== pt || des_decrypt !== dec || busy !== 1'b1) stable = 1'b0;
      if (done) done_at = n;
    end
  endtask

  logic cv_pre, cv_acc, stable;
  int   rise_at, hi_cnt, done_at;
  int   d1, d2, ndone, hi5;
  logic busy517, busy518;

  initial begin
    rst_n = 1'b1; start = 1'b0; pt_in = '0; key_in = '0; decrypt_in = 1'b0;
    src_vec = {32'hDEADBEEF, 448'h0, 32'h0000A5A5};

    // Reset asserted mid-cycle takes effect immediately
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_testmode", des_testmode, 0);
    check("rst_cap_valid", cap_valid, 0);
    check("rst_capture", capture, 0);
    check("rst_key", des_key, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single run with ordering pattern
    run_once(64'h0, KEY, 1'b0, cv_pre, cv_acc, rise_at, hi_cnt, done_at, stable);
    check("t2_rise", rise_at, 4);
    check("t2_high_cycles", hi_cnt, 512);
    check("t2_done_at", done_at, 516);
    check("t2_inputs_stable", stable, 1);
    check("t3_round1", capture[511:480], 32'hDEADBEEF);
    check("t3_round16", capture[31:0], 32'h0000A5A5);
    check("t3_capture", capture, src_vec);
    @(posedge clk); #1;
    check("t3_cap_valid", cap_valid, 1);
    check("t3_idle", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    check("t3_capture_held", capture, src_vec);

    // Start held high: second accept only from IDLE
    @(posedge clk); #1;
    pt_in = 64'h1; key_in = KEY; decrypt_in = 1'b0; start = 1'b1;
    d1 = 0; d2 = 0; ndone = 0; busy517 = 1'bx; busy518 = 1'bx;
    @(posedge clk);
    for (int n = 1; n <= 1100 && ndone < 2; n++) begin
      @(negedge clk);
      if (n == 1000) start = 1'b0;
      if (n == 517) busy517 = busy;
      if (n == 518) busy518 = busy;
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = n; else d2 = n;
      end
    end
    check("t4_done1", d1, 516);
    check("t4_idle_517", busy517, 0);
    check("t4_reaccept_518", busy518, 1);
    check("t4_done2", d2, 1033);

    // Reset during SHIFT at cnt=200
    @(posedge clk); #1;
    pt_in = 64'h5; key_in = KEY; decrypt_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hi5 = 0;
    for (int n = 1; n <= 300 && hi5 < 201; n++) begin
      @(negedge clk);
      if (des_testmode) hi5++;
    end
    check("t5_reached_cnt200", hi5, 201);
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_testmode", des_testmode, 0);
    check("t5_capture", capture, 0);
    check("t5_cap_valid", cap_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_once(64'h0000aa000000aa00, KEY, 1'b0, cv_pre, cv_acc, rise_at, hi_cnt, done_at, stable);
    check("t5_done_at", done_at, 516);
    check("t5_high_cycles", hi_cnt, 512);
    check("t5_capture", capture, src_vec);

    // Back-to-back request in the cycle after done
    for (int k = 1; k <= 16; k++) src_vec[(17-k)*32-1 -: 32] = 32'hC0DE0000 | 32'(k);
    run_once(64'h000000aa000000aa, KEY, 1'b1, cv_pre, cv_acc, rise_at, hi_cnt, done_at, stable);
    check("t6_cv_before", cv_pre, 1);
    check("t6_cv_drop", cv_acc, 0);
    check("t6_decrypt", des_decrypt, 1);
    check("t6_stable", stable, 1);
    check("t6_done_at", done_at, 516);
    check("t6_round1", capture[511:480], 32'hC0DE0001);
    check("t6_round16", capture[31:0], 32'hC0DE0010);
    @(posedge clk); #1;
    check("t6_cap_valid", cap_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
